// File: rtl/job_loader.sv
// Bcrypt job loader: deserialises a cost/salt/key frame from a narrow chunk
// stream, validates the cost, and issues a one-cycle start pulse to the core.
module job_loader #(
    parameter int DATA_W   = 8,
    parameter int SALT_W   = 128,
    parameter int KEY_W    = 576,
    parameter int COST_W   = 6,
    parameter int COST_MIN = 4,
    parameter int COST_MAX = 31
) (
    input  logic              clk,
    input  logic              int_rst_l,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              done,
    output logic              start,
    output logic [63:0]       cost_a,
    output logic [KEY_W-1:0]  salt_c,
    output logic [KEY_W-1:0]  key_c,
    output logic              busy,
    output logic              err
);

    localparam int NS    = SALT_W / DATA_W;
    localparam int NK    = KEY_W / DATA_W;
    localparam int N_MAX = (NK >= NS) ? NK : NS;
    localparam int CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam logic [CNT_W-1:0] NS_LAST = CNT_W'(NS - 1);
    localparam logic [CNT_W-1:0] NK_LAST = CNT_W'(NK - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SALT  = 3'd1,
        KEY   = 3'd2,
        START = 3'd3,
        RUN   = 3'd4,
        DRAIN = 3'd5
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [COST_W-1:0]  cost;
    logic [SALT_W-1:0]  salt_asm;
    logic [KEY_W-1:0]   key_asm;
    logic               drain_key;
    logic               xfer;
    logic [COST_W-1:0]  in_cost;
    logic               cost_ok;

    // Bit i from the top of the result takes salt bit (i mod SALT_W) from the top.
    function automatic logic [KEY_W-1:0] expand_salt(input logic [SALT_W-1:0] s);
        logic [KEY_W-1:0] r;
        r = '0;
        for (int i = 0; i < KEY_W; i++) begin
            r[KEY_W-1-i] = s[SALT_W-1-(i % SALT_W)];
        end
        return r;
    endfunction

    assign xfer    = in_valid & in_ready;
    assign in_cost = in_data[COST_W-1:0];
    assign cost_ok = (32'(in_cost) >= 32'(COST_MIN)) && (32'(in_cost) <= 32'(COST_MAX));

    // Frame sequencer; all outputs registered. Drain counts salt then key chunks.
    always_ff @(posedge clk or posedge int_rst_l) begin
        if (int_rst_l) begin
            state     <= IDLE;
            cnt       <= '0;
            cost      <= '0;
            salt_asm  <= '0;
            key_asm   <= '0;
            drain_key <= 1'b0;
            in_ready  <= 1'b0;
            start     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            cost_a    <= 64'd0;
            salt_c    <= '0;
            key_c     <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        cost      <= in_cost;
                        cnt       <= '0;
                        drain_key <= 1'b0;
                        if (cost_ok) begin
                            err   <= 1'b0;
                            state <= SALT;
                        end else begin
                            err   <= 1'b1;
                            state <= DRAIN;
                        end
                    end
                end
                SALT: begin
                    if (xfer) begin
                        salt_asm <= (salt_asm << DATA_W) | SALT_W'(in_data);
                        if (cnt == NS_LAST) begin
                            cnt   <= '0;
                            state <= KEY;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                KEY: begin
                    if (xfer) begin
                        key_asm <= (key_asm << DATA_W) | KEY_W'(in_data);
                        if (cnt == NK_LAST) begin
                            cnt      <= '0;
                            start    <= 1'b1;
                            in_ready <= 1'b0;
                            state    <= START;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                START: begin
                    cost_a <= 64'd1 << cost;
                    salt_c <= expand_salt(salt_asm);
                    key_c  <= key_asm;
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    if (done) begin
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (!drain_key) begin
                            if (cnt == NS_LAST) begin
                                cnt       <= '0;
                                drain_key <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            if (cnt == NK_LAST) begin
                                cnt       <= '0;
                                drain_key <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_job_loader.sv
// Scoreboard bench for job_loader: default 8-bit instance plus a 32-bit chunk instance.
module tb_job_loader;

    typedef struct {
        logic [63:0]  cost_a;
        logic [575:0] salt_c;
        logic [575:0] key_c;
    } exp_t;

    logic clk = 1'b0;
    logic int_rst_l = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]   in_data0 = 8'd0;
    logic         in_valid0 = 1'b0, done0 = 1'b0;
    logic         in_ready0, start0, busy0, err0;
    logic [63:0]  cost_a0;
    logic [575:0] salt_c0, key_c0;

    logic [31:0]  in_data1 = 32'd0;
    logic         in_valid1 = 1'b0, done1 = 1'b0;
    logic         in_ready1, start1, busy1, err1;
    logic [63:0]  cost_a1;
    logic [575:0] salt_c1, key_c1;

    job_loader dut0 (
        .clk(clk), .int_rst_l(int_rst_l), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .done(done0), .start(start0), .cost_a(cost_a0),
        .salt_c(salt_c0), .key_c(key_c0), .busy(busy0), .err(err0)
    );

    job_loader #(.DATA_W(32)) dut1 (
        .clk(clk), .int_rst_l(int_rst_l), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .done(done1), .start(start1), .cost_a(cost_a1),
        .salt_c(salt_c1), .key_c(key_c1), .busy(busy1), .err(err1)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    int   stalls0 = 0;
    int   xfers1 = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    logic pend0 = 1'b0, pend1 = 1'b0;

    task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitors: outputs are compared in the cycle after each start pulse.
    always @(negedge clk) begin
        if (pend0) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_start", 576'd1, 576'd0);
            end else begin
                e0 = q0.pop_front();
                chk("dut0_cost_a", 576'(cost_a0), 576'(e0.cost_a));
                chk("dut0_salt_c", salt_c0, e0.salt_c);
                chk("dut0_key_c", key_c0, e0.key_c);
                chk("dut0_busy", 576'(busy0), 576'd1);
                chk("dut0_start_width", 576'(start0), 576'd0);
            end
        end
        pend0 <= (start0 === 1'b1);
    end

    always @(negedge clk) begin
        if (pend1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_start", 576'd1, 576'd0);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_cost_a", 576'(cost_a1), 576'(e1.cost_a));
                chk("dut1_salt_c", salt_c1, e1.salt_c);
                chk("dut1_key_c", key_c1, e1.key_c);
                chk("dut1_busy", 576'(busy1), 576'd1);
            end
        end
        pend1 <= (start1 === 1'b1);
    end

    always @(posedge clk) begin
        if (in_valid1 && in_ready1) xfers1 <= xfers1 + 1;
    end

    task automatic send0(input logic [7:0] d, input bit gap);
        int n;
        if (gap && $urandom_range(0, 1) == 1) begin
            in_valid0 = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        in_data0  = d;
        in_valid0 = 1'b1;
        n = 0;
        if (in_ready0 !== 1'b1) stalls0++;
        while (in_ready0 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready0 !== 1'b1) chk("dut0_in_ready_timeout", 576'(in_ready0), 576'd1);
        @(negedge clk);
    endtask

    task automatic frame0(input logic [7:0] c, input logic [127:0] s, input logic [575:0] k,
                          input bit gap, input int nkey, output logic err_seen);
        send0(c, gap);
        err_seen = err0;
        for (int i = 0; i < 16; i++) send0(s[127-8*i -: 8], gap);
        for (int i = 0; i < nkey; i++) send0(k[575-8*i -: 8], gap);
        in_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [31:0] d);
        int n;
        in_data1  = d;
        in_valid1 = 1'b1;
        n = 0;
        while (in_ready1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready1 !== 1'b1) chk("dut1_in_ready_timeout", 576'(in_ready1), 576'd1);
        @(negedge clk);
    endtask

    task automatic finish_job0(input string nm);
        chk({nm, "_start_latency"}, 576'(start0), 576'd1);
        @(negedge clk);
        done0 = 1'b1;
        @(negedge clk);
        done0 = 1'b0;
        chk({nm, "_busy_after_done"}, 576'(busy0), 576'd0);
        chk({nm, "_ready_after_done"}, 576'(in_ready0), 576'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [575:0] salt_a_c, key_b, salt_b_c, key_s, salt_s_c;
        logic [127:0] salt_b, salt_s;
        logic         err_seen;
        exp_t         ex;

        salt_a_c = (576'd10 << 448) | (576'd10 << 320) | (576'd10 << 192) | (576'd10 << 64);
        salt_b   = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
        salt_b_c = {salt_b, salt_b, salt_b, salt_b, salt_b[127:64]};
        key_b    = {9{64'h0123_4567_89AB_CDEF}};
        salt_s   = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        salt_s_c = {salt_s, salt_s, salt_s, salt_s, salt_s[127:64]};
        key_s    = '0;
        for (int j = 0; j < 18; j++) key_s[575-32*j -: 32] = 32'h1000_0000 + 32'(j);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 576'(in_ready0), 576'd0);
        chk("rst_start", 576'(start0), 576'd0);
        chk("rst_busy", 576'(busy0), 576'd0);
        chk("rst_err", 576'(err0), 576'd0);
        chk("rst_cost_a", 576'(cost_a0), 576'd0);
        chk("rst_salt_c", salt_c0, 576'd0);
        chk("rst_key_c", key_c0, 576'd0);
        int_rst_l = 1'b0;
        @(negedge clk);
        chk("first_cycle_in_ready", 576'(in_ready0), 576'd1);

        // legal frame, in_valid held high
        ex.cost_a = 64'd256; ex.salt_c = salt_a_c; ex.key_c = 576'd89;
        q0.push_back(ex);
        frame0(8'd8, 128'd10, 576'd89, 1'b0, 72, err_seen);
        chk("a_err", 576'(err_seen), 576'd0);
        chk("a_start_latency", 576'(start0), 576'd1);
        @(negedge clk);
        in_valid0 = 1'b1;
        in_data0  = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            chk("run_in_ready_low", 576'(in_ready0), 576'd0);
            chk("run_busy", 576'(busy0), 576'd1);
        end
        in_valid0 = 1'b0;
        done0 = 1'b1;
        @(negedge clk);
        done0 = 1'b0;
        chk("a_ready_after_done", 576'(in_ready0), 576'd1);
        chk("a_busy_after_done", 576'(busy0), 576'd0);
        chk("a_cost_hold", 576'(cost_a0), 576'd256);
        chk("a_key_hold", key_c0, 576'd89);

        // same frame with random gaps
        q0.push_back(ex);
        frame0(8'd8, 128'd10, 576'd89, 1'b1, 72, err_seen);
        finish_job0("gap");

        // illegal cost drains 88 chunks with no start
        stalls0 = 0;
        frame0(8'd3, 128'hFFFF, 576'hABCD, 1'b0, 72, err_seen);
        chk("bad_err_set", 576'(err_seen), 576'd1);
        chk("bad_no_stall", 576'(stalls0), 576'd0);
        chk("bad_err_sticky", 576'(err0), 576'd1);
        chk("bad_back_idle", 576'(in_ready0), 576'd1);
        chk("bad_outputs_kept", 576'(cost_a0), 576'd256);
        repeat (3) @(negedge clk);

        // max legal cost clears err
        ex.cost_a = 64'h8000_0000; ex.salt_c = salt_b_c; ex.key_c = key_b;
        q0.push_back(ex);
        frame0(8'd31, salt_b, key_b, 1'b0, 72, err_seen);
        chk("c31_err_clear", 576'(err_seen), 576'd0);
        finish_job0("c31");

        // reset mid-key
        frame0(8'd8, 128'd10, 576'd89, 1'b0, 40, err_seen);
        #2 int_rst_l = 1'b1;
        #1;
        chk("midrst_cost_a", 576'(cost_a0), 576'd0);
        chk("midrst_key_c", key_c0, 576'd0);
        chk("midrst_salt_c", salt_c0, 576'd0);
        chk("midrst_in_ready", 576'(in_ready0), 576'd0);
        @(negedge clk);
        int_rst_l = 1'b0;
        @(negedge clk);
        ex.cost_a = 64'd256; ex.salt_c = salt_a_c; ex.key_c = 576'd89;
        q0.push_back(ex);
        frame0(8'd8, 128'd10, 576'd89, 1'b0, 72, err_seen);
        finish_job0("after_rst");

        // 32-bit chunk instance: 1 + 4 + 18 transfers
        ex.cost_a = 64'd32; ex.salt_c = salt_s_c; ex.key_c = key_s;
        q1.push_back(ex);
        send1(32'd5);
        for (int i = 0; i < 4; i++) send1(salt_s[127-32*i -: 32]);
        for (int i = 0; i < 18; i++) send1(key_s[575-32*i -: 32]);
        in_valid1 = 1'b0;
        chk("w32_start_latency", 576'(start1), 576'd1);
        chk("w32_transfers", 576'(xfers1), 576'd23);
        @(negedge clk);
        done1 = 1'b1;
        @(negedge clk);
        done1 = 1'b0;
        chk("w32_ready_after_done", 576'(in_ready1), 576'd1);

        repeat (2) @(negedge clk);
        chk("q0_drained", 576'(q0.size()), 576'd0);
        chk("q1_drained", 576'(q1.size()), 576'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/job_loader.md
Name: job_loader

Overview:
- Parametrised successor to the fixed-width cost/salt/key loader.
- Deserialises one bcrypt job frame from a narrow valid/ready chunk stream: cost, then salt, then key.
- Validates cost against a configurable range, expands salt cyclically to key width and issues a one-cycle start pulse to the core.
- Holds the job registers stable until the core's done pulse, then accepts the next frame.

Parameters:
- DATA_W, 8, input chunk width in bits; must divide SALT_W and KEY_W.
- SALT_W, 128, salt width in bits.
- KEY_W, 576, key width in bits; also the width of salt_c.
- COST_W, 6, cost field width; taken from the LSBs of the cost chunk.
- COST_MIN, 4, lowest legal cost.
- COST_MAX, 31, highest legal cost; must be ≤ 63.

Ports:
- clk  input  1  system clock, all state on rising edge
- int_rst_l  input  1  reset, asynchronous, active-high
- in_data  input  DATA_W  frame chunk
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts chunk this cycle
- done  input  1  core finished job, single-cycle pulse
- start  output  1  one-cycle job start pulse
- cost_a  output  64  round count, 1 << cost
- salt_c  output  KEY_W  salt cyclically replicated to KEY_W
- key_c  output  KEY_W  key, first chunk in MSBs
- busy  output  1  job issued, awaiting done
- err  output  1  sticky cost-range error

Behaviour:
- Reset (int_rst_l=1, async): state=IDLE; start=0, busy=0, err=0, in_ready=0; cost_a, salt_c, key_c, chunk counter all 0.
- First clock after reset release: in_ready=1.
- Transfer definition: a chunk is accepted only on a cycle with in_valid & in_ready. No transfer, no state change.
- Frame layout: 1 cost chunk, then NS=SALT_W/DATA_W salt chunks, then NK=KEY_W/DATA_W key chunks. Salt and key are MSB-first: chunk 0 lands in the top DATA_W bits, and each shift moves left by DATA_W.
- IDLE: in_ready=1. Transfer latches cost=in_data[COST_W-1:0].
  - If COST_MIN ≤ cost ≤ COST_MAX: go to SALT.
  - Otherwise: set err=1 and go to DRAIN.
  - err clears only on reset or on the next legal cost chunk.
- SALT: in_ready=1; counter counts 0..NS-1. Go to KEY after transfer NS-1, with the counter reset to 0.
- KEY: in_ready=1; counter counts 0..NK-1. Go to START after transfer NK-1.
- START (exactly 1 cycle): start=1, in_ready=0.
  - Same cycle: cost_a <= 64'd1 << cost.
  - Same cycle: salt_c[KEY_W-1-i] <= salt[SALT_W-1-(i mod SALT_W)] for i = 0..KEY_W-1.
  - Default example: four full salt copies, then the salt's top 64 bits in salt_c[63:0].
  - Next state: RUN.
- RUN: busy=1, in_ready=0. cost_a, salt_c and key_c are frozen. On done=1, go to IDLE; busy=0 the next cycle.
- DRAIN: in_ready=1. Accept and discard NS+NK chunks, then go to IDLE. No start pulse; outputs keep their previous job values.
- Latency: start is high in the cycle after the last key chunk is accepted. in_ready is low from that edge until the cycle after done.
- done handling: done is sampled only in RUN and ignored in every other state. done coinciding with reset is ignored.
- Internal registers: the salt and key assembly registers are separate from salt_c/key_c. key_c is updated in the START cycle from the assembly register. This keeps outputs unchanged during a new frame's load.
- Reset mid-frame or mid-RUN: immediate return to reset values. Any partial frame is lost.
- Counter widths: clog2(NK) bits. The counter wraps to 0 on every state change.

Test Plan:
- Reset then legal frame: cost=8, salt=128'd10, key=576'd89 at DATA_W=8 (89 chunks, in_valid held high) -> start=1 exactly 1 cycle after chunk 89; cost_a=256; key_c=576'd89; salt_c holds 10 at bit offsets 448, 320, 192, 64 and zeros in [63:0]; busy=1 until done.
- Backpressure/gaps: same frame with in_valid toggled 1-0-1 randomly -> identical outputs; chunk count is unaffected by idle cycles.
- Illegal cost: cost chunk=3, then 88 chunks -> err=1, no start, in_ready=1 throughout, back in IDLE. Then cost=31 frame -> err=0 and cost_a=64'h8000_0000.
- Held during RUN: in_valid=1 while busy -> in_ready=0 and no chunk consumed. done pulse -> in_ready=1 next cycle; outputs still hold the job values.
- Reset mid-key: assert int_rst_l after 40 chunks -> all outputs 0 immediately (async). A fresh full frame then completes normally.
- Parameter sweep: DATA_W=32, KEY_W=576, SALT_W=128 -> start after 1+4+18 transfers; salt_c replication matches the formula.
